refresher_pos8: RTL and testbench
=================================

# refresher_pos8

DRAM periodic-refresh generator with up to 8× refresh postponing. It sits between the refresh timing configuration and the controller's command multiplexer, and requests command-bus ownership through a valid/ready handshake. Once granted, it issues a burst of N (precharge-all + auto-refresh) pairs, where N is the postpone count. It also honours tRP and tRFC spacing.

## Interface
- No parameters; all timing is run-time configurable.
- sys_clk  in  1  system clock, all logic on rising edge.
- sys_rst  in  1  asynchronous, active-low reset.
- ref_tRP_cfg  in  8  precharge-to-refresh spacing, in cycles.
- ref_tRFC_cfg  in  8  refresh-to-done spacing, in cycles.
- ref_tREFI_cfg  in  12  refresh interval, in cycles.
- ref_POSTPONE_cfg  in  4  refreshes per burst; 0 acts as 1, values >8 act as 8.
- cmd_valid  out  1  requests and holds the command bus.
- cmd_ready  in  1  bus grant from the multiplexer.
- cmd_last  out  1  one-cycle pulse that releases the bus.
- cmd_payload_a  out  17  address; only bit 10 is ever set (all-bank precharge).
- cmd_payload_ba  out  3  always 0.
- cmd_payload_cas, cmd_payload_ras, cmd_payload_we  out  1 each  command encoding.

## Operation
- **Timer:** free-running down-counter.
  - Loads tREFI−1 on reset exit.
  - Pulses `tick` for one cycle at 0, then reloads.
  - Keeps running during refresh bursts.
- **Postponer:**
  - Counts ticks.
  - When the count reaches N (effective POSTPONE), clears the count and sets the sticky flag `pending`.
  - `pending` is cleared when the FSM leaves IDLE.
  - If a tick overflow and that clear happen in the same cycle, the set wins.
- **FSM states:** IDLE, WAIT_GRANT, WAIT_SEQ.
  - IDLE → WAIT_GRANT when `pending` is set.
  - WAIT_GRANT: cmd_valid=1. On cmd_ready=1, start the sequencer, latch tRP/tRFC/N, and go to WAIT_SEQ.
  - WAIT_SEQ: cmd_valid=1; cmd_ready is ignored. When the sequencer reports done: cmd_valid=0, cmd_last=1 for that cycle, then go to IDLE.
- **Sequencer:** runs the executer N times back-to-back and signals done after the Nth executer completes.
- **Executer, relative to its start cycle s:**
  - Cycle s: PRE-all (ras=1, we=1, cas=0, a=0x400).
  - Cycle s+tRP: REF (ras=1, cas=1, we=0, a=0).
  - Cycle s+tRP+tRFC: done.
  - All other cycles: NOP (cas=ras=we=0, a=0).
- **Width rules:**
  - Counters are sized to their configuration fields.
  - A tRP or tRFC of 0 is treated as 1.

## Timing
- **Reset values:** all outputs 0; FSM in IDLE; postpone count 0; `pending`=0; timer reloads.
- **First request:** the first tick comes tREFI cycles after reset release, so the first cmd_valid rises N·tREFI cycles (+1 for the FSM register) after release.
- **Grant to first command:** PRE is driven on the cycle after cmd_ready is sampled high in WAIT_GRANT.
- **Burst duration:** N·(tRP+tRFC) cycles from the first PRE to cmd_last.
- **Configuration changes:** changes during a burst have no effect until the next grant. The timer picks up a new tREFI at its next reload.
- **Reset mid-burst:** aborts immediately; outputs drop to 0 asynchronously.
- **Ticks during a burst:** still counted; an overflow sets `pending`, which is serviced right after return to IDLE.

## Structure
- **Shared package `refresher_pkg`:**
  - FSM state enum.
  - Command encodings: PRE_ALL, REF, NOP as {cas, ras, we} plus the A10 constant.
  - POSTPONE_MAX=8.
- **Sub-module `refresh_executer`:**
  - Inputs: start, tRP, tRFC.
  - Outputs: command fields, done.
  - The top level instantiates it once and re-starts it N times via a burst counter.

## Test plan
- **Nominal run:** cmd_ready=1; tRP=12, tRFC=97, tREFI=500, POSTPONE=8; reset released at 11 ns.
  - Required: cmd_valid rises about 4001 cycles after release.
  - The burst contains 8 PRE/REF pairs, with 12 cycles PRE→REF and 97 cycles REF→next PRE.
  - cmd_last pulses 872 cycles after the first PRE.
- **No postponing:** POSTPONE=1, tREFI=200 → one PRE+REF pair every 200 cycles; cmd_valid is low between bursts.
- **Delayed grant:** cmd_ready held 0 for 50 cycles after cmd_valid rises → cmd_valid stays high and no command is issued; PRE appears the cycle after cmd_ready=1.
- **Out-of-range postpone:** POSTPONE=0 behaves as 1; POSTPONE=15 behaves as 8 (8 pairs per burst).
- **Reset mid-burst:** assert sys_rst low during the 3rd REF → all outputs are 0 immediately; after release the next request comes N·tREFI later.
- **Short tREFI:** tREFI=50, N=2, tRP+tRFC=109 → the tick during the burst sets `pending`, and a new cmd_valid follows cmd_last by ≤1 cycle.

Source files
------------

// File: rtl/refresher_pos8_pkg.sv
// rtl/refresher_pos8_pkg.sv - shared types, command encodings and helpers for the refresh generator
package refresher_pkg;

    localparam logic [3:0] POSTPONE_MAX = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_GRANT = 2'd1,
        ST_WAIT_SEQ   = 2'd2
    } ref_state_e;

    // DRAM command bits packed as {cas, ras, we}
    typedef logic [2:0] dram_cmd_t;

    localparam dram_cmd_t   CMD_PRE_ALL = 3'b011;
    localparam dram_cmd_t   CMD_REF     = 3'b110;
    localparam dram_cmd_t   CMD_NOP     = 3'b000;
    localparam logic [16:0] A10         = 17'h00400;

    // Reload value for a spacing counter; a spacing of 0 behaves as 1.
    function automatic logic [7:0] span_reload(input logic [7:0] span);
        return (span == 8'd0) ? 8'd0 : span - 8'd1;
    endfunction

    function automatic logic [3:0] postpone_eff(input logic [3:0] cfg);
        if (cfg == 4'd0) begin
            return 4'd1;
        end
        if (cfg > POSTPONE_MAX) begin
            return POSTPONE_MAX;
        end
        return cfg;
    endfunction

endpackage

// File: rtl/refresher_pos8_if.sv
// rtl/refresher_pos8_if.sv - command-bus request/grant and payload bundle toward the command multiplexer
interface refresher_pos8_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_last;
    logic [16:0] cmd_payload_a;
    logic [2:0]  cmd_payload_ba;
    logic        cmd_payload_cas;
    logic        cmd_payload_ras;
    logic        cmd_payload_we;

    modport master (
        output cmd_valid, cmd_last, cmd_payload_a, cmd_payload_ba,
               cmd_payload_cas, cmd_payload_ras, cmd_payload_we,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_last, cmd_payload_a, cmd_payload_ba,
               cmd_payload_cas, cmd_payload_ras, cmd_payload_we,
        output cmd_ready
    );

endinterface

// File: rtl/refresher_pos8_executer.sv
// rtl/refresher_pos8_executer.sv - one PRE-all + REF pair with tRP/tRFC spacing
module refresh_executer
    import refresher_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       start_i,
    input  logic [7:0] trp_i,
    input  logic [7:0] trfc_i,
    output dram_cmd_t  cmd_o,
    output logic       a10_o,
    output logic       done_o
);

    typedef enum logic [1:0] {EX_IDLE, EX_RP, EX_RFC} ex_phase_e;

    ex_phase_e phase_q, phase_d;
    logic [7:0] cnt_q, cnt_d;
    dram_cmd_t  cmd_q, cmd_d;
    logic       a10_q, a10_d;

    // High during the final cycle of a run, so a restart lands its PRE on the very next cycle.
    assign done_o = (phase_q == EX_RFC) && (cnt_q == 8'd0);
    assign cmd_o  = cmd_q;
    assign a10_o  = a10_q;

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        cmd_d   = CMD_NOP;
        a10_d   = 1'b0;
        if (start_i) begin
            phase_d = EX_RP;
            cnt_d   = span_reload(trp_i);
            cmd_d   = CMD_PRE_ALL;
            a10_d   = 1'b1;
        end else begin
            case (phase_q)
                EX_RP: begin
                    if (cnt_q == 8'd0) begin
                        phase_d = EX_RFC;
                        cnt_d   = span_reload(trfc_i);
                        cmd_d   = CMD_REF;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                EX_RFC: begin
                    if (cnt_q == 8'd0) begin
                        phase_d = EX_IDLE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                default: begin
                    phase_d = EX_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            phase_q <= EX_IDLE;
            cnt_q   <= 8'd0;
            cmd_q   <= CMD_NOP;
            a10_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            a10_q   <= a10_d;
        end
    end

endmodule

// File: rtl/refresher_pos8.sv
// rtl/refresher_pos8.sv - periodic DRAM refresh generator with up to 8x postponing and bus handshake
module refresher_pos8
    import refresher_pkg::*;
(
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [7:0]        ref_tRP_cfg,
    input  logic [7:0]        ref_tRFC_cfg,
    input  logic [11:0]       ref_tREFI_cfg,
    input  logic [3:0]        ref_POSTPONE_cfg,
    refresher_pos8_if.master  cmd
);

    // Interval timer: the first cycle after reset behaves as a fresh load of tREFI-1.
    logic        armed_q;
    logic [11:0] timer_q, timer_d, timer_cur;
    logic        tick;

    assign timer_cur = armed_q ? timer_q : ref_tREFI_cfg - 12'd1;
    assign tick      = (timer_cur == 12'd0);
    assign timer_d   = tick ? ref_tREFI_cfg - 12'd1 : timer_cur - 12'd1;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            armed_q <= 1'b0;
            timer_q <= 12'd0;
        end else begin
            armed_q <= 1'b1;
            timer_q <= timer_d;
        end
    end

    ref_state_e state_q;
    logic       pending_q, pending_d;
    logic [3:0] post_cnt_q, post_cnt_d;
    logic       overflow, pending_clr;

    assign overflow    = tick && ((post_cnt_q + 4'd1) >= postpone_eff(ref_POSTPONE_cfg));
    assign post_cnt_d  = !tick ? post_cnt_q : (overflow ? 4'd0 : post_cnt_q + 4'd1);
    assign pending_clr = (state_q == ST_IDLE) && pending_q;
    assign pending_d   = overflow | (pending_q & ~pending_clr);

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            post_cnt_q <= 4'd0;
            pending_q  <= 1'b0;
        end else begin
            post_cnt_q <= post_cnt_d;
            pending_q  <= pending_d;
        end
    end

    logic       valid_q, last_q;
    logic [7:0] trp_q, trfc_q;
    logic [3:0] burst_left_q;
    logic       grant, exec_start, exec_done, exec_a10;
    logic [7:0] exec_trp;
    dram_cmd_t  exec_cmd;

    assign grant      = (state_q == ST_WAIT_GRANT) && cmd.cmd_ready;
    assign exec_start = grant || ((state_q == ST_WAIT_SEQ) && exec_done && (burst_left_q != 4'd0));
    // The first pair starts on the grant edge, before the latched copy is valid.
    assign exec_trp   = grant ? ref_tRP_cfg : trp_q;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q      <= ST_IDLE;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            trp_q        <= 8'd0;
            trfc_q       <= 8'd0;
            burst_left_q <= 4'd0;
        end else begin
            last_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pending_q) begin
                        state_q <= ST_WAIT_GRANT;
                        valid_q <= 1'b1;
                    end
                end
                ST_WAIT_GRANT: begin
                    if (cmd.cmd_ready) begin
                        state_q      <= ST_WAIT_SEQ;
                        trp_q        <= ref_tRP_cfg;
                        trfc_q       <= ref_tRFC_cfg;
                        burst_left_q <= postpone_eff(ref_POSTPONE_cfg) - 4'd1;
                    end
                end
                ST_WAIT_SEQ: begin
                    if (exec_done) begin
                        if (burst_left_q == 4'd0) begin
                            state_q <= ST_IDLE;
                            valid_q <= 1'b0;
                            last_q  <= 1'b1;
                        end else begin
                            burst_left_q <= burst_left_q - 4'd1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    refresh_executer u_exec (
        .clk_i   (sys_clk),
        .rst_n_i (sys_rst),
        .start_i (exec_start),
        .trp_i   (exec_trp),
        .trfc_i  (trfc_q),
        .cmd_o   (exec_cmd),
        .a10_o   (exec_a10),
        .done_o  (exec_done)
    );

    assign cmd.cmd_valid       = valid_q;
    assign cmd.cmd_last        = last_q;
    assign cmd.cmd_payload_a   = exec_a10 ? A10 : 17'd0;
    assign cmd.cmd_payload_ba  = 3'd0;
    assign cmd.cmd_payload_cas = exec_cmd[2];
    assign cmd.cmd_payload_ras = exec_cmd[1];
    assign cmd.cmd_payload_we  = exec_cmd[0];

endmodule

// File: tb/tb_refresher_pos8.sv
// tb/tb_refresher_pos8.sv - scoreboard bench with a cycle-level timeline model of refresh requests and bursts
module tb_refresher_pos8;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic [7:0]  trp_cfg = 8'd0;
    logic [7:0]  trfc_cfg = 8'd0;
    logic [11:0] trefi_cfg = 12'd0;
    logic [3:0]  pp_cfg = 4'd0;

    refresher_pos8_if bus();

    refresher_pos8 dut (
        .sys_clk          (sys_clk),
        .sys_rst          (sys_rst),
        .ref_tRP_cfg      (trp_cfg),
        .ref_tRFC_cfg     (trfc_cfg),
        .ref_tREFI_cfg    (trefi_cfg),
        .ref_POSTPONE_cfg (pp_cfg),
        .cmd              (bus)
    );

    always #5 sys_clk = ~sys_clk;

    typedef enum int {EV_RISE, EV_FALL, EV_PRE, EV_REF, EV_LAST} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       cyc;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fails  = 0;
    int  cyc = 0;
    int  rel = 0;
    bit  pv  = 1'b0;

    // Timeline model state for the current run
    int peff, feff, neff, refi, served, idle_from;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint got, input longint want);
        n_checks++;
        if (got != want) begin
            n_fails++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    function automatic logic [24:0] outs();
        return {bus.cmd_valid, bus.cmd_last, bus.cmd_payload_ba, bus.cmd_payload_a,
                bus.cmd_payload_cas, bus.cmd_payload_ras, bus.cmd_payload_we};
    endfunction

    task automatic push(input ev_kind_e k, input int c);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_kind_e k, input int cy);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk($sformatf("unexpected_%s", k.name()), cy, -1);
            return;
        end
        e = exp_q.pop_front();
        chk($sformatf("%s_kind", e.kind.name()), int'(k), int'(e.kind));
        chk($sformatf("%s_cycle", e.kind.name()), cy, e.cyc);
    endtask

    // Monitor: turns every observable output change or command into an event for the scoreboard.
    always @(negedge sys_clk) begin
        int cy;
        logic [2:0] c;
        if (!sys_rst) begin
            pv = 1'b0;
        end else begin
            cy = cyc - rel;
            c  = {bus.cmd_payload_cas, bus.cmd_payload_ras, bus.cmd_payload_we};
            chk("payload", {bus.cmd_payload_ba, bus.cmd_payload_a}, (c == 3'b011) ? 20'h00400 : 20'h0);
            if (c != 3'b000 && c != 3'b011 && c != 3'b110) chk("cmd_encoding", c, 0);
            if (bus.cmd_valid && !pv) observe(EV_RISE, cy);
            if (!bus.cmd_valid && pv && !bus.cmd_last) observe(EV_FALL, cy);
            if (c == 3'b011) observe(EV_PRE, cy);
            if (c == 3'b110) observe(EV_REF, cy);
            if (bus.cmd_last) begin
                observe(EV_LAST, cy);
                chk("valid_low_at_last", bus.cmd_valid, 0);
            end
            pv = bus.cmd_valid;
        end
    end

    task automatic wait_cycle(input int c);
        while (cyc - rel < c) begin
            @(posedge sys_clk);
            #2;
        end
    endtask

    task automatic release_run(input int p, input int f, input int r, input int n);
        trp_cfg   = 8'(p);
        trfc_cfg  = 8'(f);
        trefi_cfg = 12'(r);
        pp_cfg    = 4'(n);
        peff = (p == 0) ? 1 : p;
        feff = (f == 0) ? 1 : f;
        neff = (n == 0) ? 1 : ((n > 8) ? 8 : n);
        refi = r;
        repeat (2) @(posedge sys_clk);
        #2;
        chk("reset_outputs", outs(), 0);
        sys_rst   = 1'b1;
        rel       = cyc;
        served    = 1;
        idle_from = 0;
    endtask

    // Plans one burst: request after the next unserved N-th tick, grant d cycles later.
    task automatic run_burst(input int d, input int stop_ref);
        int nr, t, v, g, s0, s, l;
        nr = neff * refi;
        t  = ((served + nr - 1) / nr) * nr;
        v  = ((t > idle_from) ? t : idle_from) + 1;
        s  = peff + feff;
        g  = v + d;
        s0 = g + 1;
        l  = s0 + neff * s;
        push(EV_RISE, v);
        for (int k = 0; k < neff; k++) begin
            push(EV_PRE, s0 + k * s);
            if (k == stop_ref) break;
            push(EV_REF, s0 + k * s + peff);
        end
        if (stop_ref < 0) push(EV_LAST, l);
        wait_cycle(g);
        bus.cmd_ready = 1'b1;
        if (stop_ref >= 0) begin
            wait_cycle(s0 + stop_ref * s + peff);
            sys_rst = 1'b0;
            #1;
            chk("mid_burst_reset_outputs", outs(), 0);
            bus.cmd_ready = 1'b0;
        end else begin
            wait_cycle(l);
            bus.cmd_ready = 1'b0;
            served    = v;
            idle_from = l;
        end
    endtask

    task automatic end_run();
        #4;
        chk("drain", exp_q.size(), 0);
        exp_q.delete();
        sys_rst = 1'b0;
    endtask

    initial begin
        bus.cmd_ready = 1'b0;

        release_run(12, 97, 500, 8);
        run_burst(0, -1);
        end_run();

        release_run(12, 97, 200, 1);
        repeat (3) run_burst(0, -1);
        end_run();

        release_run(5, 20, 300, 1);
        run_burst(50, -1);
        run_burst(3, -1);
        end_run();

        release_run(4, 9, 150, 0);
        repeat (2) run_burst(1, -1);
        end_run();

        release_run(3, 10, 100, 15);
        repeat (2) run_burst(0, -1);
        end_run();

        release_run(12, 97, 50, 2);
        repeat (3) run_burst(0, -1);
        end_run();

        release_run(10, 30, 100, 4);
        run_burst(0, 2);
        end_run();
        release_run(10, 30, 100, 4);
        run_burst(0, -1);
        end_run();

        release_run(0, 0, 60, 3);
        repeat (2) run_burst(2, -1);
        end_run();

        for (int i = 0; i < 4; i++) begin
            release_run(int'($urandom_range(0, 15)), int'($urandom_range(0, 40)),
                        int'($urandom_range(40, 250)), int'($urandom_range(0, 15)));
            repeat (2) run_burst(int'($urandom_range(0, 6)), -1);
            end_run();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
